// File: rtl/memory_system.sv
// Word-addressed memory with a direct-mapped, write-through, write-around cache.
// Misses and writes stall the requester for MEM_LATENCY+1 cycles.
module memory_system #(
    parameter int MEM_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        WE,
    input  logic        RE,
    input  logic [9:0]  A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        stall
);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0]   mem   [1024];
    logic [31:0]   cdata [128];
    logic [2:0]    ctag  [32];
    logic [31:0]   valid;
    logic [9:0]    req_addr;
    logic [31:0]   req_data;
    logic [CW-1:0] cnt;
    logic [4:0]    idx;
    logic          hit;
    logic          last;

    assign idx  = A[6:2];
    assign hit  = (RE | WE) && valid[idx] && (ctag[idx] == A[9:7]);
    assign last = (cnt == CW'(MEM_LATENCY - 1));

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        RD         = 32'h0;
        unique case (state)
            IDLE: begin
                if (WE) begin
                    stall      = 1'b1;
                    next_state = WRITE;
                end else if (RE) begin
                    if (hit) begin
                        RD = cdata[{idx, A[1:0]}];
                    end else begin
                        stall      = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            FETCH, WRITE: begin
                stall = 1'b1;
                if (last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE || last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state == FETCH && last) begin
                valid[req_addr[6:2]] <= 1'b1;
            end
        end
    end

    // Request is captured at issue so later input changes cannot corrupt it
    always_ff @(posedge clk) begin
        if (state == IDLE && (WE || RE)) begin
            req_addr <= A;
            req_data <= WD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n && state == WRITE && last) begin
            mem[req_addr] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n && state == FETCH && last) begin
            for (int k = 0; k < 4; k++) begin
                cdata[{req_addr[6:2], 2'(k)}] <= mem[{req_addr[9:2], 2'(k)}];
            end
            ctag[req_addr[6:2]] <= req_addr[9:7];
        end else if (state == IDLE && WE && hit) begin
            cdata[{idx, A[1:0]}] <= WD;
        end
    end
endmodule

// File: tb/tb_memory_system.sv
// Randomized check of memory_system against a transaction-level model
// of memory contents plus per-line valid/tag state.
module tb_memory_system;
    localparam int L = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        WE;
    logic        RE;
    logic [9:0]  A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        stall;

    int errors = 0;
    int checks = 0;

    logic        exp_on = 1'b0;
    logic        exp_stall;
    logic [31:0] exp_rd;

    logic [31:0] mem_m [1024];
    bit          vld_m [32];
    logic [2:0]  tag_m [32];

    memory_system #(.MEM_LATENCY(L)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .WE     (WE),
        .RE     (RE),
        .A      (A),
        .WD     (WD),
        .RD     (RD),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_on) begin
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL stall t=%0t A=%0d: got %b want %b", $time, A, stall, exp_stall);
            end
            checks++;
            if (RD !== exp_rd) begin
                errors++;
                $display("FAIL rd t=%0t A=%0d: got %h want %h", $time, A, RD, exp_rd);
            end
        end
    end

    task automatic step(input bit on, input bit es, input logic [31:0] er,
                        input bit lon = 1'b0, input logic [31:0] lit = '0,
                        input string nm = "");
        exp_on    = on;
        exp_stall = es;
        exp_rd    = er;
        @(negedge clk);
        #1;
        if (lon) begin
            checks++;
            if (RD !== lit) begin
                errors++;
                $display("FAIL %s: RD=%h expected %h", nm, RD, lit);
            end
        end
        @(posedge clk);
        #1;
        exp_on = 1'b0;
    endtask

    task automatic scramble();
        WE = 1'($urandom);
        RE = 1'($urandom);
        A  = 10'($urandom);
        WD = $urandom;
    endtask

    task automatic clear_valid();
        for (int i = 0; i < 32; i++) vld_m[i] = 1'b0;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input bit both);
        WE = 1'b1; RE = both; A = a; WD = d;
        step(1'b1, 1'b1, 32'h0);
        for (int i = 0; i < L; i++) begin
            scramble();
            step(1'b1, 1'b1, 32'h0);
        end
        mem_m[a] = d;
        WE = 1'b0; RE = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a, input bit lon = 1'b0,
                           input logic [31:0] lit = '0, input string nm = "");
        logic [4:0] ix;
        bit         hit;
        ix  = a[6:2];
        hit = vld_m[ix] && (tag_m[ix] == a[9:7]);
        WE = 1'b0; RE = 1'b1; A = a; WD = $urandom;
        if (!hit) begin
            step(1'b1, 1'b1, 32'h0);
            for (int i = 0; i < L; i++) begin
                scramble();
                step(1'b1, 1'b1, 32'h0);
            end
            vld_m[ix] = 1'b1;
            tag_m[ix] = a[9:7];
            WE = 1'b0; RE = 1'b1; A = a;
        end
        step(1'b1, 1'b0, mem_m[a], lon, lit, nm);
        RE = 1'b0;
    endtask

    task automatic reset_cycle();
        WE = 1'b0; RE = 1'b0;
        reset_n = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        reset_n = 1'b0;
        clear_valid();
        step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic abort_read(input logic [9:0] a);
        WE = 1'b0; RE = 1'b1; A = a;
        step(1'b1, 1'b1, 32'h0);
        step(1'b1, 1'b1, 32'h0);
        RE = 1'b0;
        reset_n = 1'b1;
        step(1'b1, 1'b1, 32'h0);
        reset_n = 1'b0;
        clear_valid();
        step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic abort_write(input logic [9:0] a, input logic [31:0] d);
        WE = 1'b1; RE = 1'b0; A = a; WD = d;
        step(1'b1, 1'b1, 32'h0);
        step(1'b1, 1'b1, 32'h0);
        WE = 1'b0;
        reset_n = 1'b1;
        step(1'b1, 1'b1, 32'h0);
        reset_n = 1'b0;
        clear_valid();
        step(1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        int          op;
        logic [9:0]  ra;
        reset_n = 1'b1;
        WE = 1'b0; RE = 1'b0; A = '0; WD = '0;
        clear_valid();
        for (int i = 0; i < 32; i++) tag_m[i] = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        step(1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 1024; i++) do_write(10'(i), $urandom, 1'b0);

        do_write(10'd10, 32'd50, 1'b0);
        do_read(10'd10, 1'b1, 32'd50, "read10");

        do_write(10'd20, 32'd51, 1'b0);
        do_write(10'd30, 32'd52, 1'b0);
        do_read(10'd20, 1'b1, 32'd51, "read20");
        do_read(10'd21);

        do_read(10'd30, 1'b1, 32'd52, "read30_pre");
        do_write(10'd30, 32'd53, 1'b0);
        do_read(10'd30, 1'b1, 32'd53, "read30_hit");

        do_read(10'd10, 1'b1, 32'd50, "read10_hit");
        do_read(10'd138);
        do_read(10'd10, 1'b1, 32'd50, "read10_refill");

        do_write(10'd10, 32'd99, 1'b1);
        do_read(10'd10, 1'b1, 32'd99, "read10_both");

        abort_read(10'd200);
        do_read(10'd200);
        abort_write(10'd10, 32'd77);
        do_read(10'd10, 1'b1, 32'd99, "read10_abort");
        reset_cycle();
        do_read(10'd30, 1'b1, 32'd53, "read30_mem");

        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 99);
            ra = {3'($urandom), 3'b000, 2'($urandom), 2'($urandom)};
            if (op < 50) begin
                do_read(ra);
            end else if (op < 83) begin
                do_write(ra, $urandom, 1'b0);
            end else if (op < 91) begin
                do_write(ra, $urandom, 1'b1);
            end else if (op < 97) begin
                WE = 1'b0; RE = 1'b0; A = 10'($urandom);
                step(1'b1, 1'b0, 32'h0);
            end else begin
                reset_cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory_system.md
MEMORY_SYSTEM -- requirements
Module: memory_system

Interface
REQ-001 Parameter MEM_LATENCY, default 3: main-memory access time in clock cycles, >=1.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset; synchronous, active-high (asserted = 1) despite the name.
REQ-004 WE  input  1  write request.
REQ-005 RE  input  1  read request.
REQ-006 A  input  10  word address (1024 x 32-bit word space).
REQ-007 WD  input  32  write data.
REQ-008 RD  output  32  read data.
REQ-009 stall  output  1  request not complete; requester SHALL hold WE/RE/A/WD stable while stall=1.

Function
REQ-010 Block SHALL contain a 1024x32 main memory and a direct-mapped cache of 32 lines x 4 words, with one valid bit and a 3-bit tag per line.
REQ-011 Address split: tag = A[9:7], index = A[6:2], word offset = A[1:0].
REQ-012 Hit = RE or WE asserted, valid[index]=1 and tag[index]=A[9:7].
REQ-013 FSM states: IDLE, FETCH, WRITE; a counter times MEM_LATENCY cycles in FETCH and WRITE.
REQ-014 If WE and RE are both 1, the write SHALL take priority and RE SHALL be ignored.
REQ-015 IDLE, RE=1, hit: RD = cached word combinationally, stall=0, state stays IDLE.
REQ-016 IDLE, RE=1, miss: stall=1 combinationally in the same cycle; next state FETCH.
REQ-017 FETCH: stall=1 for MEM_LATENCY cycles; on the last cycle's edge, write the 4-word block (A[9:2]) into the line, set tag and valid, and return to IDLE.
REQ-018 A read miss SHALL show stall=1 for exactly MEM_LATENCY+1 cycles; in the following cycle the same request hits with stall=0 and correct RD.
REQ-019 IDLE, WE=1: stall=1 combinationally; next state WRITE; on a hit, the cached word is updated with WD on that first edge.
REQ-020 A write miss SHALL NOT allocate a line (write-around).
REQ-021 WRITE: stall=1 for MEM_LATENCY cycles; on the last cycle's edge, write WD to main memory at A, then return to IDLE (write-through).
REQ-022 A write SHALL show stall=1 for exactly MEM_LATENCY+1 cycles.
REQ-023 If WE is still 1 in IDLE after completion, a new write SHALL start; repeating an identical write is harmless.
REQ-024 RD SHALL be 32'h0 whenever no read hit is presented in IDLE, including during FETCH and WRITE.
REQ-025 IDLE with WE=0 and RE=0: stall=0, no state change.
REQ-026 Request inputs are sampled in IDLE only; changes during FETCH or WRITE are ignored.
REQ-027 A miss on a line valid with a different tag SHALL overwrite that line; no writeback is needed because the cache is write-through.

Reset
REQ-028 reset_n=1 at a rising edge SHALL clear all valid bits, force IDLE and clear the counter; stall=0 and RD=0 in the following cycle.
REQ-029 Reset SHALL abort FETCH or WRITE mid-operation: an aborted fetch leaves the line invalid, and an aborted write does not update main memory.
REQ-030 Reset SHALL NOT alter main-memory contents or cache data/tag arrays, only valid bits and control state.

Verification
REQ-031 Reset; then WE=1 A=10 WD=50 -> stall=1 for 4 cycles; line 2 stays invalid; then RE=1 A=10 -> stall=1 for 4 cycles, then RD=50 with stall=0.
REQ-032 Write 51@20 and 52@30, then read 20 -> miss, 4 stall cycles, RD=51; read 21 next -> immediate hit, stall=0, RD = mem[21].
REQ-033 After 30 is cached, write 53@30 -> 4 stall cycles; then read 30 -> hit, stall=0, RD=53; main memory at 30 also holds 53.
REQ-034 Read 10 (cached), then read 138 (same index, tag 1) -> miss and refill; re-read 10 -> miss again with 4 stall cycles and RD=50.
REQ-035 RE=1 and WE=1 together at A=10 with WD=99 -> write performed (4 stall cycles, RD=0); a later read of 10 returns 99.
REQ-036 Assert reset during the second FETCH cycle -> next cycle IDLE, stall=0; a repeated read of the same address misses again.
